// File: rtl/physics_pkg.sv
// Shared fixed-point constants, FSM encoding and saturation helper for the pig physics blocks.
package physics_pkg;

    localparam int unsigned FRAC_BITS = 6;
    localparam int unsigned WORD      = 17;

    // Half a pixel per frame in Q10.6.
    localparam logic [WORD-1:0] HALF_PX = WORD'(1) << (FRAC_BITS - 1);

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        HOLD  = 2'd1,
        COOL  = 2'd2
    } state_e;

    function automatic logic signed [WORD-1:0] saturate(input logic signed [WORD:0] val,
                                                        input logic [WORD-1:0]     fmax);
        logic signed [WORD:0] v_max;
        logic signed [WORD:0] v_min;
        v_max = $signed({1'b0, fmax});
        v_min = -v_max;
        if (val > v_max) begin
            saturate = v_max[WORD-1:0];
        end else if (val < v_min) begin
            saturate = v_min[WORD-1:0];
        end else begin
            saturate = val[WORD-1:0];
        end
    endfunction

endpackage

// File: rtl/pig_collision_force_if.sv
// Pixel-stream inputs and impulse outputs between the scan logic and one pig collision block.
interface pig_collision_force_if;

    logic                                 vsync;
    logic                                 pig;
    logic                                 bird;
    logic [3:0]                           pig_dir;
    logic signed [physics_pkg::WORD-1:0]  bird_vx;
    logic signed [physics_pkg::WORD-1:0]  bird_vy;
    logic signed [physics_pkg::WORD-1:0]  pig_force_x;
    logic signed [physics_pkg::WORD-1:0]  pig_force_y;
    logic                                 hit;
    logic                                 armed;

    modport master (
        output vsync, pig, bird, pig_dir, bird_vx, bird_vy,
        input  pig_force_x, pig_force_y, hit, armed
    );

    modport slave (
        input  vsync, pig, bird, pig_dir, bird_vx, bird_vy,
        output pig_force_x, pig_force_y, hit, armed
    );

endinterface

// File: rtl/overlap_binner.sv
// Per-frame saturating overlap counters binned by pig quadrant, cleared on every vsync.
module overlap_binner #(
    parameter logic [10:0] MIN_OVERLAP = 11'd4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_vsync,
    input  logic i_ov,
    input  logic i_right,
    input  logic i_below,
    output logic o_lft_gt_rgt,
    output logic o_rgt_gt_lft,
    output logic o_abv_gt_bel,
    output logic o_bel_gt_abv,
    output logic o_tot_hit
);

    logic [10:0] r_tot;
    logic [10:0] r_rgt;
    logic [10:0] r_lft;
    logic [10:0] r_bel;
    logic [10:0] r_abv;

    function automatic logic [10:0] sat_inc(input logic [10:0] c);
        return (c == 11'h7ff) ? c : c + 11'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tot <= '0;
            r_rgt <= '0;
            r_lft <= '0;
            r_bel <= '0;
            r_abv <= '0;
        end else if (i_vsync) begin
            r_tot <= '0;
            r_rgt <= '0;
            r_lft <= '0;
            r_bel <= '0;
            r_abv <= '0;
        end else if (i_ov) begin
            r_tot <= sat_inc(r_tot);
            if (i_right) begin
                r_rgt <= sat_inc(r_rgt);
            end else begin
                r_lft <= sat_inc(r_lft);
            end
            if (i_below) begin
                r_bel <= sat_inc(r_bel);
            end else begin
                r_abv <= sat_inc(r_abv);
            end
        end
    end

    assign o_lft_gt_rgt = (r_lft > r_rgt);
    assign o_rgt_gt_lft = (r_rgt > r_lft);
    assign o_abv_gt_bel = (r_abv > r_bel);
    assign o_bel_gt_abv = (r_bel > r_abv);
    assign o_tot_hit    = (r_tot >= MIN_OVERLAP);

endmodule

// File: rtl/pig_collision_force.sv
// Turns per-frame pig/bird overlap into a one-frame signed impulse on the pig, then cools down.
module pig_collision_force
    import physics_pkg::*;
#(
    parameter logic [10:0]     MIN_OVERLAP = 11'd4,
    parameter logic [2:0]      FORCE_SHIFT = 3'd1,
    parameter logic [WORD-1:0] KICK        = HALF_PX,
    parameter logic [3:0]      COOLDOWN    = 4'd8,
    parameter logic [WORD-1:0] FMAX        = 17'd16383
) (
    input logic                  clk,
    input logic                  rst_n,
    pig_collision_force_if.slave bus
);

    state_e                 r_state;
    state_e                 w_state_next;
    logic [3:0]             r_cd;
    logic [3:0]             w_cd_next;
    logic signed [WORD-1:0] r_fx;
    logic signed [WORD-1:0] r_fy;
    logic signed [WORD-1:0] w_fx_next;
    logic signed [WORD-1:0] w_fy_next;
    logic                   r_hit;
    logic                   w_hit_next;

    logic w_ov;
    logic w_lft_gt_rgt;
    logic w_rgt_gt_lft;
    logic w_abv_gt_bel;
    logic w_bel_gt_abv;
    logic w_tot_hit;
    logic [1:0] w_unused_dir;

    logic signed [WORD:0] w_kick;
    logic signed [WORD:0] w_vx_ext;
    logic signed [WORD:0] w_vy_ext;
    logic signed [WORD:0] w_kx;
    logic signed [WORD:0] w_ky;
    logic signed [WORD:0] w_fx_sum;
    logic signed [WORD:0] w_fy_sum;

    // Band bits are already implied by the pig mask itself.
    assign w_unused_dir = bus.pig_dir[3:2];
    assign w_ov         = bus.pig & bus.bird & ~bus.vsync;

    overlap_binner #(
        .MIN_OVERLAP (MIN_OVERLAP)
    ) u_binner (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_vsync      (bus.vsync),
        .i_ov         (w_ov),
        .i_right      (bus.pig_dir[1]),
        .i_below      (bus.pig_dir[0]),
        .o_lft_gt_rgt (w_lft_gt_rgt),
        .o_rgt_gt_lft (w_rgt_gt_lft),
        .o_abv_gt_bel (w_abv_gt_bel),
        .o_bel_gt_abv (w_bel_gt_abv),
        .o_tot_hit    (w_tot_hit)
    );

    // Momentum transfer plus a push away from the struck half, in one extra bit of headroom.
    assign w_kick   = $signed({1'b0, KICK});
    assign w_vx_ext = $signed({bus.bird_vx[WORD-1], bus.bird_vx});
    assign w_vy_ext = $signed({bus.bird_vy[WORD-1], bus.bird_vy});
    assign w_kx     = w_lft_gt_rgt ? w_kick : (w_rgt_gt_lft ? -w_kick : '0);
    assign w_ky     = w_abv_gt_bel ? w_kick : (w_bel_gt_abv ? -w_kick : '0);
    assign w_fx_sum = (w_vx_ext >>> FORCE_SHIFT) + w_kx;
    assign w_fy_sum = (w_vy_ext >>> FORCE_SHIFT) + w_ky;

    always_comb begin
        w_state_next = r_state;
        w_cd_next    = r_cd;
        w_fx_next    = r_fx;
        w_fy_next    = r_fy;
        w_hit_next   = 1'b0;
        if (bus.vsync) begin
            unique case (r_state)
                ARMED: begin
                    if (w_tot_hit) begin
                        w_fx_next    = saturate(w_fx_sum, FMAX);
                        w_fy_next    = saturate(w_fy_sum, FMAX);
                        w_hit_next   = 1'b1;
                        w_state_next = HOLD;
                    end
                end
                HOLD: begin
                    w_fx_next = '0;
                    w_fy_next = '0;
                    if (COOLDOWN == 4'd0) begin
                        w_state_next = ARMED;
                    end else begin
                        w_state_next = COOL;
                        w_cd_next    = COOLDOWN - 4'd1;
                    end
                end
                COOL: begin
                    if (r_cd == 4'd0) begin
                        w_state_next = ARMED;
                    end else begin
                        w_cd_next = r_cd - 4'd1;
                    end
                end
                default: begin
                    w_state_next = ARMED;
                    w_fx_next    = '0;
                    w_fy_next    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARMED;
            r_cd    <= '0;
            r_fx    <= '0;
            r_fy    <= '0;
            r_hit   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cd    <= w_cd_next;
            r_fx    <= w_fx_next;
            r_fy    <= w_fy_next;
            r_hit   <= w_hit_next;
        end
    end

    assign bus.pig_force_x = r_fx;
    assign bus.pig_force_y = r_fy;
    assign bus.hit         = r_hit;
    assign bus.armed       = (r_state == ARMED);

endmodule

// File: tb/tb_pig_collision_force.sv
// Directed bench for pig_collision_force: frame-level behavioural model plus literal spot checks.
module tb_pig_collision_force;

    localparam int MINOV = 4;
    localparam int SHIFT = 1;
    localparam int KICKV = 32;
    localparam int CD    = 2;
    localparam int FMAXV = 16383;
    localparam int CMAX  = 2047;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pig_collision_force_if bus();

    pig_collision_force #(
        .MIN_OVERLAP (11'(MINOV)),
        .FORCE_SHIFT (3'(SHIFT)),
        .KICK        (17'(KICKV)),
        .COOLDOWN    (4'(CD)),
        .FMAX        (17'(FMAXV))
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level model: plain integer bins, a hold flag and frames of cooldown remaining.
    int m_tot, m_lft, m_rgt, m_abv, m_bel;
    int m_cool, m_fx, m_fy;
    bit m_hold, m_hit;

    function automatic int bump(input int c);
        return (c < CMAX) ? c + 1 : c;
    endfunction

    function automatic int impulse(input int vel, input int pos_cnt, input int neg_cnt);
        int f;
        f = (vel >>> SHIFT) + ((pos_cnt > neg_cnt) ? KICKV : ((neg_cnt > pos_cnt) ? -KICKV : 0));
        if (f > FMAXV) f = FMAXV;
        if (f < -FMAXV) f = -FMAXV;
        return f;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tot <= 0; m_lft <= 0; m_rgt <= 0; m_abv <= 0; m_bel <= 0;
            m_cool <= 0; m_fx <= 0; m_fy <= 0; m_hold <= 1'b0; m_hit <= 1'b0;
        end else begin
            m_hit <= 1'b0;
            if (bus.vsync) begin
                m_tot <= 0; m_lft <= 0; m_rgt <= 0; m_abv <= 0; m_bel <= 0;
                if (m_hold) begin
                    m_hold <= 1'b0;
                    m_fx   <= 0;
                    m_fy   <= 0;
                    m_cool <= CD;
                end else if (m_cool > 0) begin
                    m_cool <= m_cool - 1;
                end else if (m_tot >= MINOV) begin
                    m_hold <= 1'b1;
                    m_hit  <= 1'b1;
                    m_fx   <= impulse(int'(bus.bird_vx), m_lft, m_rgt);
                    m_fy   <= impulse(int'(bus.bird_vy), m_abv, m_bel);
                end
            end else if (bus.pig && bus.bird) begin
                m_tot <= bump(m_tot);
                if (bus.pig_dir[1]) m_rgt <= bump(m_rgt);
                else                m_lft <= bump(m_lft);
                if (bus.pig_dir[0]) m_bel <= bump(m_bel);
                else                m_abv <= bump(m_abv);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_force_x", int'(bus.pig_force_x), m_fx);
            check("model_force_y", int'(bus.pig_force_y), m_fy);
            check("model_hit", int'(bus.hit), int'(m_hit));
            check("model_armed", int'(bus.armed), int'(!m_hold && m_cool == 0));
        end
    end

    task automatic cyc(input logic v, input logic p, input logic b, input logic [3:0] d);
        @(negedge clk);
        bus.vsync   = v;
        bus.pig     = p;
        bus.bird    = b;
        bus.pig_dir = d;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 4'b0000);
    endtask

    // n overlap pixels, with some non-overlapping pig-only / bird-only pixels mixed in.
    task automatic ovl(input int n, input logic [3:0] d);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, 1'b1, d);
            if (i % 7 == 3) cyc(1'b0, 1'b1, 1'b0, d);
            if (i % 11 == 5) cyc(1'b0, 1'b0, 1'b1, d);
        end
    endtask

    // Leaves the bench at the first sampling point after the frame boundary.
    task automatic vsync_idle();
        cyc(1'b1, 1'b0, 1'b0, 4'b0000);
        idle();
    endtask

    task automatic drain(input string name);
        repeat (3) vsync_idle();
        check(name, int'(bus.armed), 1);
    endtask

    task automatic set_vel(input int vx, input int vy);
        bus.bird_vx = 17'(vx);
        bus.bird_vy = 17'(vy);
    endtask

    initial begin
        bus.vsync   = 1'b0;
        bus.pig     = 1'b0;
        bus.bird    = 1'b0;
        bus.pig_dir = 4'b0000;
        set_vel(0, 0);

        repeat (2) @(negedge clk);
        check("reset_armed", int'(bus.armed), 1);
        check("reset_force_x", int'(bus.pig_force_x), 0);
        check("reset_hit", int'(bus.hit), 0);
        rst_n = 1'b1;

        // Reset mid-frame discards the partial counts.
        ovl(50, 4'b1001);
        idle();
        #2 rst_n = 1'b0;
        #1 check("midreset_armed", int'(bus.armed), 1);
        @(negedge clk);
        rst_n = 1'b1;
        vsync_idle();
        check("midreset_nohit", int'(bus.hit), 0);
        check("midreset_armed2", int'(bus.armed), 1);

        // Left/below strike.
        set_vel(128, 0);
        ovl(20, 4'b1001);
        vsync_idle();
        check("left_fx", int'(bus.pig_force_x), 96);
        check("left_fy", int'(bus.pig_force_y), -32);
        check("left_hit", int'(bus.hit), 1);
        check("left_hold", int'(bus.armed), 0);
        check("model_pin_fx", m_fx, 96);
        idle();
        check("left_hit_once", int'(bus.hit), 0);
        check("left_fx_held", int'(bus.pig_force_x), 96);

        // Hold then cooldown with overlaps in each frame.
        ovl(100, 4'b1001);
        vsync_idle();
        check("hold_end_fx", int'(bus.pig_force_x), 0);
        check("cool1_armed", int'(bus.armed), 0);
        ovl(100, 4'b1001);
        vsync_idle();
        check("cool2_armed", int'(bus.armed), 0);
        ovl(100, 4'b1001);
        vsync_idle();
        check("rearm_armed", int'(bus.armed), 1);
        check("rearm_nohit", int'(bus.hit), 0);
        set_vel(-64, 64);
        ovl(10, 4'b1010);
        vsync_idle();
        check("right_fx", int'(bus.pig_force_x), -64);
        check("right_fy", int'(bus.pig_force_y), 64);
        check("right_hit", int'(bus.hit), 1);
        drain("drain1");

        // Threshold boundary.
        set_vel(0, 0);
        ovl(3, 4'b1000);
        vsync_idle();
        check("below_min_hit", int'(bus.hit), 0);
        check("below_min_fx", int'(bus.pig_force_x), 0);
        check("below_min_armed", int'(bus.armed), 1);
        ovl(4, 4'b1000);
        vsync_idle();
        check("at_min_hit", int'(bus.hit), 1);
        check("at_min_fx", int'(bus.pig_force_x), 32);
        check("at_min_fy", int'(bus.pig_force_y), 32);
        drain("drain2");

        // Saturation both ways.
        set_vel(32767, -65536);
        ovl(10, 4'b1000);
        vsync_idle();
        check("sat_pos_fx", int'(bus.pig_force_x), 16383);
        check("sat_neg_fy", int'(bus.pig_force_y), -16383);
        check("model_pin_sat", m_fx, 16383);
        drain("drain3");
        set_vel(65535, 0);
        ovl(10, 4'b1011);
        vsync_idle();
        check("sat_max_fx", int'(bus.pig_force_x), 16383);
        check("sat_max_fy", int'(bus.pig_force_y), -32);
        drain("drain4");

        // Tie, with an overlap pixel in the vsync cycle that must be ignored.
        set_vel(-64, 0);
        ovl(5, 4'b1000);
        ovl(5, 4'b1011);
        cyc(1'b1, 1'b1, 1'b1, 4'b1011);
        idle();
        check("tie_fx", int'(bus.pig_force_x), -32);
        check("tie_fy", int'(bus.pig_force_y), 0);
        check("tie_hit", int'(bus.hit), 1);
        drain("drain5");

        // Counters saturate at 2047, turning 2100 vs 2060 into a tie.
        set_vel(0, 0);
        ovl(2100, 4'b1011);
        ovl(2060, 4'b1000);
        vsync_idle();
        check("cnt_sat_hit", int'(bus.hit), 1);
        check("cnt_sat_fx", int'(bus.pig_force_x), 0);
        check("cnt_sat_fy", int'(bus.pig_force_y), 0);
        drain("drain6");

        // Back-to-back vsync cycles each count as a frame boundary.
        ovl(6, 4'b1001);
        vsync_idle();
        check("b2b_fx", int'(bus.pig_force_x), 32);
        cyc(1'b1, 1'b0, 1'b0, 4'b0000);
        cyc(1'b1, 1'b0, 1'b0, 4'b0000);
        idle();
        check("b2b_cool", int'(bus.armed), 0);
        check("b2b_fx_clear", int'(bus.pig_force_x), 0);
        vsync_idle();
        check("b2b_rearm", int'(bus.armed), 1);

        // Reset while holding an impulse.
        set_vel(128, 0);
        ovl(8, 4'b1001);
        vsync_idle();
        check("hold_fx_pre_reset", int'(bus.pig_force_x), 96);
        #2 rst_n = 1'b0;
        #1 check("hold_reset_fx", int'(bus.pig_force_x), 0);
        check("hold_reset_armed", int'(bus.armed), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
